// File: rtl/skin_detect_pipe.sv
// Skin-tone detect/recolour: 3-stage RGB pipeline with debounced button control.
// Ports: clk, n_rst, i_vid_* in, btn[3:0], o_vid_* out, o_mode, o_y_min; SKIN_COUNT_EN adds o_skin_count/o_count_valid.
module skin_detect_pipe #(
  parameter int                 DW        = 8,
  parameter int                 DEBOUNCE  = 250000,
  parameter logic [DW-1:0]      Y_MIN     = 80,
  parameter logic signed [DW:0] CB_MIN    = -40,
  parameter logic signed [DW:0] CB_MAX    = 10,
  parameter logic signed [DW:0] CR_MIN    = 20,
  parameter logic signed [DW:0] CR_MAX    = 90,
  parameter int                 Y_STEP    = 4,
  parameter logic [3*DW-1:0]    HL_COLOUR = 24'h00FF00
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [3*DW-1:0] i_vid_data,
  input  logic            i_vid_hsync,
  input  logic            i_vid_vsync,
  input  logic            i_vid_VDE,
  input  logic [3:0]      btn,
  output logic [3*DW-1:0] o_vid_data,
  output logic            o_vid_hsync,
  output logic            o_vid_vsync,
  output logic            o_vid_VDE,
  output logic [1:0]      o_mode,
`ifdef SKIN_COUNT_EN
  output logic [23:0]     o_skin_count,
  output logic            o_count_valid,
`endif
  output logic [DW-1:0]   o_y_min
);

  typedef enum logic [1:0] {
    M_PASS   = 2'd0,
    M_HILITE = 2'd1,
    M_MASK   = 2'd2,
    M_BLEND  = 2'd3
  } mode_e;

  localparam int            CW      = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(DEBOUNCE - 1);
  localparam logic [DW-1:0] YMAX    = '1;

  // ---------------- buttons ----------------
  logic [3:0]    sy1_q, sy2_q, stb_q;
  logic [CW-1:0] cnt_q [4];
  logic [3:0]    press;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sy1_q <= '0;
      sy2_q <= '0;
      stb_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sy1_q <= btn;
      sy2_q <= sy1_q;
      for (int i = 0; i < 4; i++) begin
        // a return to the accepted level restarts the stability count
        if (sy2_q[i] == stb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_TOP) begin
          stb_q[i] <= sy2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    press = '0;
    for (int i = 0; i < 4; i++)
      press[i] = sy2_q[i] & ~stb_q[i] & (cnt_q[i] == CNT_TOP);
  end

  // ---------------- shadow / active ----------------
  mode_e         mode_sh_q, mode_sh_d, mode_q;
  logic [DW-1:0] ymin_sh_q, ymin_sh_d, ymin_q;
  logic [DW:0]   y_up;
  logic          vs_in_q;
  logic          fb;

  assign fb   = i_vid_vsync & ~vs_in_q;
  assign y_up = {1'b0, ymin_sh_q} + (DW+1)'(Y_STEP);

  always_comb begin
    mode_sh_d = mode_sh_q;
    ymin_sh_d = ymin_sh_q;
    if (press[3]) begin
      mode_sh_d = M_PASS;
      ymin_sh_d = Y_MIN;
    end else begin
      if (press[0]) mode_sh_d = mode_e'(mode_sh_q + 2'd1);
      if (press[1] && !press[2])
        ymin_sh_d = (y_up > {1'b0, YMAX}) ? YMAX : y_up[DW-1:0];
      else if (press[2] && !press[1])
        ymin_sh_d = (ymin_sh_q < DW'(Y_STEP)) ? '0
                  : ymin_sh_q - DW'(Y_STEP);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mode_sh_q <= M_PASS;
      ymin_sh_q <= Y_MIN;
      mode_q    <= M_PASS;
      ymin_q    <= Y_MIN;
      vs_in_q   <= 1'b0;
    end else begin
      mode_sh_q <= mode_sh_d;
      ymin_sh_q <= ymin_sh_d;
      vs_in_q   <= i_vid_vsync;
      // boundary takes the pre-press shadow; a same-cycle press waits a frame
      if (fb) begin
        mode_q <= mode_sh_q;
        ymin_q <= ymin_sh_q;
      end
    end
  end

  assign o_mode  = mode_q;
  assign o_y_min = ymin_q;

  // ---------------- S1: luma / chroma difference ----------------
  logic [DW-1:0]      r_c, g_c, b_c;
  logic [DW+1:0]      ysum;
  logic [DW-1:0]      y1_q;
  logic signed [DW:0] cb1_q, cr1_q;
  logic [3*DW-1:0]    pix1_q;
  logic               hs1_q, vs1_q, de1_q;

  assign r_c  = i_vid_data[3*DW-1:2*DW];
  assign g_c  = i_vid_data[2*DW-1:DW];
  assign b_c  = i_vid_data[DW-1:0];
  assign ysum = {2'b0, r_c} + {1'b0, g_c, 1'b0} + {2'b0, b_c};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      y1_q   <= '0;
      cb1_q  <= '0;
      cr1_q  <= '0;
      pix1_q <= '0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      de1_q  <= 1'b0;
    end else begin
      y1_q   <= ysum[DW+1:2];
      cb1_q  <= $signed({1'b0, b_c}) - $signed({1'b0, g_c});
      cr1_q  <= $signed({1'b0, r_c}) - $signed({1'b0, g_c});
      pix1_q <= i_vid_data;
      hs1_q  <= i_vid_hsync;
      vs1_q  <= i_vid_vsync;
      de1_q  <= i_vid_VDE;
    end
  end

  // ---------------- S2: threshold compare ----------------
  logic            skin_c, skin2_q;
  logic [3*DW-1:0] pix2_q;
  logic            hs2_q, vs2_q, de2_q;

  assign skin_c = de1_q && (y1_q > ymin_q)
               && (cb1_q > CB_MIN) && (cb1_q < CB_MAX)
               && (cr1_q > CR_MIN) && (cr1_q < CR_MAX);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      skin2_q <= 1'b0;
      pix2_q  <= '0;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
      de2_q   <= 1'b0;
    end else begin
      skin2_q <= skin_c;
      pix2_q  <= pix1_q;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      de2_q   <= de1_q;
    end
  end

  // ---------------- S3: recolour ----------------
  logic [DW:0]     bsum;
  logic [3*DW-1:0] blend_c, data3_d, data3_q;
  logic            hs3_q, vs3_q, de3_q;

  always_comb begin
    bsum    = '0;
    blend_c = '0;
    for (int c = 0; c < 3; c++) begin
      bsum = {1'b0, pix2_q[c*DW +: DW]} + {1'b0, HL_COLOUR[c*DW +: DW]};
      blend_c[c*DW +: DW] = bsum[DW:1];
    end
  end

  always_comb begin
    data3_d = '0;
    if (de2_q) begin
      unique case (mode_q)
        M_PASS:   data3_d = pix2_q;
        M_HILITE: data3_d = skin2_q ? HL_COLOUR : pix2_q;
        M_MASK:   data3_d = skin2_q ? '1 : '0;
        M_BLEND:  data3_d = skin2_q ? blend_c : pix2_q;
        default:  data3_d = pix2_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data3_q <= '0;
      hs3_q   <= 1'b0;
      vs3_q   <= 1'b0;
      de3_q   <= 1'b0;
    end else begin
      data3_q <= data3_d;
      hs3_q   <= hs2_q;
      vs3_q   <= vs2_q;
      de3_q   <= de2_q;
    end
  end

  assign o_vid_data  = data3_q;
  assign o_vid_hsync = hs3_q;
  assign o_vid_vsync = vs3_q;
  assign o_vid_VDE   = de3_q;

`ifdef SKIN_COUNT_EN
  logic [23:0] scnt_q, scnt_o_q;
  logic        cval_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      scnt_q   <= '0;
      scnt_o_q <= '0;
      cval_q   <= 1'b0;
    end else begin
      cval_q <= fb;
      if (fb) begin
        scnt_o_q <= scnt_q;
        // a skin pixel on the boundary cycle opens the new frame's count
        scnt_q   <= {23'd0, skin_c};
      end else if (skin_c && scnt_q != '1) begin
        scnt_q <= scnt_q + 24'd1;
      end
    end
  end

  assign o_skin_count  = scnt_o_q;
  assign o_count_valid = cval_q;
`endif

endmodule

// File: tb/tb_skin_detect_pipe.sv
// Directed bench for skin_detect_pipe (DEBOUNCE=4).
// Hand-computed vectors: latency, modes, thresholds, buttons, optional count.
module tb_skin_detect_pipe;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [23:0] i_vid_data;
  logic        i_vid_hsync, i_vid_vsync, i_vid_VDE;
  logic [3:0]  btn;
  logic [23:0] o_vid_data;
  logic        o_vid_hsync, o_vid_vsync, o_vid_VDE;
  logic [1:0]  o_mode;
  logic [7:0]  o_y_min;
`ifdef SKIN_COUNT_EN
  logic [23:0] o_skin_count;
  logic        o_count_valid;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  skin_detect_pipe #(.DEBOUNCE(DB)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_vid_data  (i_vid_data),
    .i_vid_hsync (i_vid_hsync),
    .i_vid_vsync (i_vid_vsync),
    .i_vid_VDE   (i_vid_VDE),
    .btn         (btn),
    .o_vid_data  (o_vid_data),
    .o_vid_hsync (o_vid_hsync),
    .o_vid_vsync (o_vid_vsync),
    .o_vid_VDE   (o_vid_VDE),
    .o_mode      (o_mode),
`ifdef SKIN_COUNT_EN
    .o_skin_count (o_skin_count),
    .o_count_valid(o_count_valid),
`endif
    .o_y_min     (o_y_min)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic px(input logic [23:0] d, input logic de);
    i_vid_data = d;
    i_vid_VDE  = de;
    step(3);
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    step(DB + 4);
    btn = '0;
    step(DB + 4);
  endtask

  task automatic frame();
    i_vid_vsync = 1'b1;
    step(1);
    i_vid_vsync = 1'b0;
    step(1);
  endtask

  localparam logic [23:0] SKIN = 24'hC89678;
  localparam logic [23:0] GREY = 24'h202020;

  initial begin
    n_rst       = 1'b0;
    i_vid_data  = '0;
    i_vid_hsync = 1'b0;
    i_vid_vsync = 1'b0;
    i_vid_VDE   = 1'b0;
    btn         = '0;
    step(3);
    chk("rst_data", o_vid_data, 0);
    chk("rst_de", o_vid_VDE, 0);
    chk("rst_mode", o_mode, 0);
    chk("rst_ymin", o_y_min, 80);
    n_rst = 1'b1;
    step(1);

    // latency: two pixels with hsync/vsync markers
    i_vid_data = 24'h123456; i_vid_VDE = 1; i_vid_hsync = 1; i_vid_vsync = 1;
    step(1);
    i_vid_data = 24'hABCDEF; i_vid_hsync = 0; i_vid_vsync = 0;
    step(1);
    chk("lat_early", o_vid_data, 0);
    chk("lat_early_de", o_vid_VDE, 0);
    i_vid_data = '0; i_vid_VDE = 0;
    step(1);
    chk("lat_p1", o_vid_data, 24'h123456);
    chk("lat_sync1", {o_vid_hsync, o_vid_vsync, o_vid_VDE}, 3'b111);
    step(1);
    chk("lat_p2", o_vid_data, 24'hABCDEF);
    chk("lat_sync2", {o_vid_hsync, o_vid_vsync, o_vid_VDE}, 3'b001);
    px(SKIN, 0);
    chk("pass_vde0", o_vid_data, 0);

    // HILITE
    press(4'b0001);
    chk("mode_wait", o_mode, 0);
    frame();
    chk("mode_hl", o_mode, 1);
    px(SKIN, 1);
    chk("hl_skin", o_vid_data, 24'h00FF00);
    px(GREY, 1);
    chk("hl_grey", o_vid_data, GREY);
    px(24'h694B41, 1);
    chk("hl_y_eq", o_vid_data, 24'h694B41);
    px(24'h694B45, 1);
    chk("hl_y_gt", o_vid_data, 24'h00FF00);
    px(24'hC8966E, 1);
    chk("hl_cb_eq", o_vid_data, 24'hC8966E);
    px(SKIN, 0);
    chk("hl_vde0", o_vid_data, 0);

    // MASK
    press(4'b0001);
    frame();
    chk("mode_mask", o_mode, 2);
    px(SKIN, 1);
    chk("mask_skin", o_vid_data, 24'hFFFFFF);
    px(GREY, 1);
    chk("mask_grey", o_vid_data, 0);
    px(SKIN, 0);
    chk("mask_vde0", o_vid_data, 0);

    // BLEND
    press(4'b0001);
    frame();
    chk("mode_blend", o_mode, 3);
    px(SKIN, 1);
    chk("blend_skin", o_vid_data, 24'h64CA3C);
    px(GREY, 1);
    chk("blend_grey", o_vid_data, GREY);
    px(SKIN, 0);
    chk("blend_vde0", o_vid_data, 0);
    i_vid_VDE = 0;

    // bounce shorter than debounce window
    for (int k = 0; k < 3; k++) begin
      btn = 4'b0010; step(2);
      btn = 4'b0000; step(2);
    end
    step(10);
    frame();
    chk("bounce", o_y_min, 80);

    // stable Y up: only after vsync rise
    press(4'b0010);
    chk("yup_wait", o_y_min, 80);
    frame();
    chk("yup", o_y_min, 84);

    // press landing on the boundary cycle
    btn = 4'b0010;
    step(5);
    i_vid_vsync = 1'b1;
    step(1);
    i_vid_vsync = 1'b0;
    chk("bnd_same", o_y_min, 84);
    step(2);
    btn = '0;
    step(DB + 4);
    frame();
    chk("bnd_next", o_y_min, 88);

    // Y down saturation
    for (int k = 0; k < 25; k++) press(4'b0100);
    frame();
    chk("ydn_sat", o_y_min, 0);

    // restore has priority over Y up
    press(4'b1010);
    frame();
    chk("restore_y", o_y_min, 80);
    chk("restore_mode", o_mode, 0);

    // up and down together cancel
    press(4'b0110);
    frame();
    chk("updn", o_y_min, 80);

`ifdef SKIN_COUNT_EN
    i_vid_VDE = 0;
    step(4);
    frame();
    for (int k = 0; k < 15; k++) begin
      i_vid_data = (k < 10) ? SKIN : GREY;
      i_vid_VDE  = 1'b1;
      step(1);
    end
    i_vid_VDE = 0;
    step(4);
    i_vid_vsync = 1'b1;
    step(1);
    i_vid_vsync = 1'b0;
    chk("cnt_valid", o_count_valid, 1);
    chk("cnt_val", o_skin_count, 10);
    step(1);
    chk("cnt_pulse", o_count_valid, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
